// File: rtl/bell_strike_sched_if.sv
// Button-pulse and bell-drive bundle between the edge detectors, the strike
// scheduler and the bell output driver.
interface bell_strike_sched_if;
  logic       cnt_up;
  logic       cnt_dn;
  logic       tmp_up;
  logic       tmp_dn;
  logic       start;
  logic       stop;
  logic       ring;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic [4:0] tempo;

  modport master (
    output cnt_up, cnt_dn, tmp_up, tmp_dn, start, stop,
    input  ring, busy, done, count, tempo
  );

  modport slave (
    input  cnt_up, cnt_dn, tmp_up, tmp_dn, start, stop,
    output ring, busy, done, count, tempo
  );
endinterface

// File: rtl/bell_strike_sched.sv
// Bell strike scheduler: plays `count` strikes at the selected tempo from one period down-counter.
// Optional BELL_REPEAT_EN: bursts loop with a REPEAT_GAP-period pause until stop or reset.
module bell_strike_sched #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int REPEAT_GAP = 2
) (
  input logic               clk,
  input logic               _rst,
  bell_strike_sched_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; count/tempo adjustable
  // HIGH  | ring high for H = P/2 cycles
  // LOW   | ring low for P-H cycles, then next strike or burst end
  // PAUSE | repeat build only: REPEAT_GAP*P idle cycles before the next burst
`ifdef BELL_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HIGH, LOW, PAUSE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

  logic [31:0] period_tbl [20];
  for (genvar g = 0; g < 20; g++) begin : g_tbl
    assign period_tbl[g] = 32'((64'd2 * 64'(CLK_HZ)) / 64'(g + 1));
  end

  state_t      state;
  logic [31:0] period;
  logic [31:0] tmr;
  logic [31:0] half;
  logic [31:0] p_sel;
  logic [3:0]  remaining;
  logic [3:0]  count_q;
  logic [4:0]  tempo_q;
  logic        ring_q;
  logic        busy_q;
  logic        done_q;

  assign p_sel = period_tbl[tempo_q];
  assign half  = period >> 1;

`ifdef BELL_REPEAT_EN
  logic [3:0]  burst_len;
  logic [31:0] gap_len;
  assign gap_len = period * 32'(REPEAT_GAP);
`else
  // REPEAT_GAP only matters in the repeat build.
  logic unused_gap;
  assign unused_gap = ^REPEAT_GAP;
`endif

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      count_q <= 4'd1;
      tempo_q <= 5'd1;
    end else if (state == IDLE) begin
      if (bus.cnt_up && !bus.cnt_dn && count_q != 4'd9)
        count_q <= count_q + 4'd1;
      else if (bus.cnt_dn && !bus.cnt_up && count_q != 4'd1)
        count_q <= count_q - 4'd1;
      if (bus.tmp_up && !bus.tmp_dn && tempo_q != 5'd19)
        tempo_q <= tempo_q + 5'd1;
      else if (bus.tmp_dn && !bus.tmp_up && tempo_q != 5'd0)
        tempo_q <= tempo_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state     <= IDLE;
      period    <= '0;
      tmr       <= '0;
      remaining <= '0;
      ring_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BELL_REPEAT_EN
      burst_len <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // stop outranks any phase completion landing in the same cycle
      if (state != IDLE && bus.stop) begin
        state  <= IDLE;
        ring_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state     <= HIGH;
              period    <= p_sel;
              tmr       <= (p_sel >> 1) - 32'd1;
              remaining <= count_q;
              ring_q    <= 1'b1;
              busy_q    <= 1'b1;
`ifdef BELL_REPEAT_EN
              burst_len <= count_q;
`endif
            end
          end
          HIGH: begin
            if (tmr == 32'd0) begin
              state  <= LOW;
              ring_q <= 1'b0;
              tmr    <= period - half - 32'd1;
            end else begin
              tmr <= tmr - 32'd1;
            end
          end
          LOW: begin
            if (tmr == 32'd0) begin
              remaining <= remaining - 4'd1;
              if (remaining == 4'd1) begin
                done_q <= 1'b1;
`ifdef BELL_REPEAT_EN
                state  <= PAUSE;
                tmr    <= gap_len - 32'd1;
`else
                state  <= IDLE;
                busy_q <= 1'b0;
`endif
              end else begin
                state  <= HIGH;
                ring_q <= 1'b1;
                tmr    <= half - 32'd1;
              end
            end else begin
              tmr <= tmr - 32'd1;
            end
          end
`ifdef BELL_REPEAT_EN
          PAUSE: begin
            if (tmr == 32'd0) begin
              state     <= HIGH;
              ring_q    <= 1'b1;
              tmr       <= half - 32'd1;
              remaining <= burst_len;
            end else begin
              tmr <= tmr - 32'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ring  = ring_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.tempo = tempo_q;
endmodule
